// File: rtl/dmem_responder_if.sv
// Single-word load/store handshake between the MEM stage (master) and the data memory (slave).
// The master holds req until it sees ready=1 at a sampling edge; the slave answers with a one-cycle ack.
interface dmem_responder_if #(
    parameter int ADDR_W = 8
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              ready;
    logic              ack;
    logic [31:0]       rdata;
    logic              err;

    modport master (
        output req, we, addr, wdata,
        input  ready, ack, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output ready, ack, rdata, err
    );
endinterface

// File: rtl/dmem_responder.sv
// Data memory for the MEM stage: one request at a time, ack LATENCY+1 cycles after acceptance.
// No queueing: ready is low from acceptance through the ack cycle, and req is ignored meanwhile.
module dmem_responder #(
    parameter int DEPTH   = 64,
    parameter int ADDR_W  = 8,
    parameter int LATENCY = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    dmem_responder_if.slave  bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              ready_q, ready_d;
    logic              ack_q, ack_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [31:0]       mem_q [DEPTH];
    logic [31:0]       mem_d [DEPTH];

    logic              acc_go;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [31:0]       acc_wdata;
    logic              acc_in_range;
    logic [IDX_W-1:0]  acc_idx;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        mem_d     = mem_q;
        rdata_d   = 32'd0;
        err_d     = 1'b0;
        acc_go    = 1'b0;
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;

        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    we_d    = bus.we;
                    addr_d  = bus.addr;
                    wdata_d = bus.wdata;
                    cnt_d   = LATENCY[3:0];
                    if (LATENCY == 0) begin
                        // Zero latency: the access happens on the accepting edge itself.
                        state_d   = RESP;
                        acc_go    = 1'b1;
                        acc_we    = bus.we;
                        acc_addr  = bus.addr;
                        acc_wdata = bus.wdata;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                    acc_go  = 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        acc_in_range = int'(acc_addr) < DEPTH;
        acc_idx      = acc_addr[IDX_W-1:0];
        if (acc_go) begin
            err_d = !acc_in_range;
            if (acc_in_range) begin
                if (acc_we) begin
                    mem_d[acc_idx] = acc_wdata;
                end else begin
                    rdata_d = mem_q[acc_idx];
                end
            end
        end

        ready_d = (state_d == IDLE);
        ack_d   = (state_d == RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            ready_q <= 1'b1;
            ack_q   <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'(i);
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            ready_q <= ready_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            mem_q   <= mem_d;
        end
    end

    assign bus.ready = ready_q;
    assign bus.ack   = ack_q;
    assign bus.rdata = rdata_q;
    assign bus.err   = err_q;
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 and a LATENCY=0 instance share clock and reset,
// compared against a word-array model of memory contents and a cycle-count model of timing.
module tb_dmem_responder;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    dmem_responder_if #(.ADDR_W(8)) a_if ();
    dmem_responder_if #(.ADDR_W(8)) b_if ();

    dmem_responder #(.DEPTH(64), .ADDR_W(8), .LATENCY(2)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (a_if.slave)
    );

    dmem_responder #(.DEPTH(64), .ADDR_W(8), .LATENCY(0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b_if.slave)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] model_a [64];
    logic [31:0] model_b [64];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            model_a[i] = 32'(i);
            model_b[i] = 32'(i);
        end
    endtask

    task automatic drive(input int sel, input logic r, input logic w,
                         input logic [7:0] a, input logic [31:0] d);
        if (sel == 0) begin
            a_if.req = r; a_if.we = w; a_if.addr = a; a_if.wdata = d;
        end else begin
            b_if.req = r; b_if.we = w; b_if.addr = a; b_if.wdata = d;
        end
    endtask

    function automatic logic rdy(input int sel);
        return (sel == 0) ? a_if.ready : b_if.ready;
    endfunction

    function automatic logic ackv(input int sel);
        return (sel == 0) ? a_if.ack : b_if.ack;
    endfunction

    function automatic logic [31:0] rdv(input int sel);
        return (sel == 0) ? a_if.rdata : b_if.rdata;
    endfunction

    function automatic logic errv(input int sel);
        return (sel == 0) ? a_if.err : b_if.err;
    endfunction

    // One full transaction: present, wait for acceptance, scramble inputs, time the ack.
    task automatic xact(input int sel, input logic w, input logic [7:0] a,
                        input logic [31:0] d, input string tag);
        int          guard;
        int          lat;
        int          lowc;
        logic        got;
        logic [31:0] rd;
        logic        e;
        logic        oor;
        logic [31:0] exp_rd;
        int          exp_lat;

        exp_lat = (sel == 0) ? 3 : 1;
        oor     = (a >= 8'd64);
        exp_rd  = 32'd0;
        if (!oor && !w) exp_rd = (sel == 0) ? model_a[a[5:0]] : model_b[a[5:0]];

        @(negedge clk);
        drive(sel, 1'b1, w, a, d);
        guard = 0;
        while (!rdy(sel) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, " accept_wait"}, 32'(guard), 32'd0);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 1'($urandom), 8'($urandom), $urandom);

        lat = 0; lowc = 0; got = 1'b0; rd = 32'hx; e = 1'bx;
        while (!got && lat < 30) begin
            @(negedge clk);
            lat++;
            if (!rdy(sel)) lowc++;
            if (ackv(sel)) begin
                got = 1'b1;
                rd  = rdv(sel);
                e   = errv(sel);
            end
        end
        chk({tag, " ack_latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " ready_low_cycles"}, 32'(lowc), 32'(exp_lat));
        chk({tag, " rdata"}, rd, exp_rd);
        chk({tag, " err"}, 32'(e), 32'(oor));

        @(negedge clk);
        chk({tag, " ack_one_cycle"}, 32'(ackv(sel)), 32'd0);
        chk({tag, " rdata_cleared"}, rdv(sel), 32'd0);
        chk({tag, " err_cleared"}, 32'(errv(sel)), 32'd0);
        chk({tag, " ready_back"}, 32'(rdy(sel)), 32'd1);

        if (!oor && w) begin
            if (sel == 0) model_a[a[5:0]] = d;
            else          model_b[a[5:0]] = d;
        end
    endtask

    initial begin
        int          nacc;
        int          nack;
        int          cyc;
        int          acc_c [3];
        logic [31:0] ackd [3];
        logic [31:0] exp_back [3];
        int          ack_seen;

        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 8'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 8'd0, 32'd0);
        model_reset();
        #12;
        chk("reset ready", 32'(a_if.ready), 32'd1);
        chk("reset ack", 32'(a_if.ack), 32'd0);
        chk("reset rdata", a_if.rdata, 32'd0);
        chk("reset err", 32'(a_if.err), 32'd0);
        chk("reset ready_l0", 32'(b_if.ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        xact(0, 1'b0, 8'd5, 32'd0, "load5");

        xact(0, 1'b1, 8'd9, 32'hDEADBEEF, "store9");
        xact(0, 1'b0, 8'd9, 32'd0, "load9");
        chk("load9 model", model_a[9], 32'hDEADBEEF);
        xact(0, 1'b0, 8'd10, 32'd0, "load10");

        // Back-to-back: req held high across three loads of addresses 1,2,3.
        for (int i = 0; i < 3; i++) exp_back[i] = model_a[i + 1];
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 8'd1, 32'd0);
        nacc = 0; nack = 0; cyc = 0;
        while ((nacc < 3 || nack < 3) && cyc < 60) begin
            if (a_if.ack) begin
                if (nack < 3) ackd[nack] = a_if.rdata;
                nack++;
            end
            if (a_if.ready && a_if.req) begin
                acc_c[nacc] = cyc;
                nacc++;
                @(posedge clk);
                #1;
                if (nacc < 3) drive(0, 1'b1, 1'b0, 8'(nacc + 1), 32'd0);
                else          drive(0, 1'b0, 1'b0, 8'd0, 32'd0);
            end
            @(negedge clk);
            cyc++;
        end
        chk("b2b accepts", 32'(nacc), 32'd3);
        chk("b2b acks", 32'(nack), 32'd3);
        chk("b2b spacing01", 32'(acc_c[1] - acc_c[0]), 32'd4);
        chk("b2b spacing12", 32'(acc_c[2] - acc_c[1]), 32'd4);
        for (int i = 0; i < 3; i++) chk("b2b rdata", ackd[i], exp_back[i]);

        xact(0, 1'b0, 8'd70, 32'd0, "load70");
        xact(0, 1'b1, 8'd70, 32'hFFFF0000, "store70");

        for (int i = 0; i < 40; i++) begin
            xact(0, 1'($urandom), 8'($urandom_range(0, 79)), $urandom, "rand_a");
        end
        for (int i = 0; i < 64; i++) begin
            xact(0, 1'b0, 8'(i), 32'd0, "scan_a");
        end

        // Reset while a store is waiting: store is dropped, memory returns to its init pattern.
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 8'd4, 32'h1234);
        @(posedge clk);
        #1;
        drive(0, 1'b0, 1'b0, 8'd0, 32'd0);
        @(negedge clk);
        chk("rstwait in_wait", 32'(a_if.ready), 32'd0);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rstwait ready", 32'(a_if.ready), 32'd1);
        chk("rstwait ack", 32'(a_if.ack), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ack_seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (a_if.ack) ack_seen++;
        end
        chk("rstwait no_ack", 32'(ack_seen), 32'd0);
        xact(0, 1'b0, 8'd4, 32'd0, "load4_after_rst");

        xact(1, 1'b0, 8'd7, 32'd0, "l0_load7");
        for (int i = 0; i < 20; i++) begin
            xact(1, 1'($urandom), 8'($urandom_range(0, 79)), $urandom, "rand_b");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
